// File: rtl/blink_pkg.sv
// Shared types and divider helpers for the blink tick generator.
// Used by blink_tick_gen and btn_debounce.
package blink_pkg;

  typedef logic [1:0] speed_t;

  localparam speed_t      SPEED_MAX       = 2'd3;
  localparam int unsigned SPEED_SHIFT_MAX = 3;

  // Width of a counter that must hold DIV_BASE << SPEED_SHIFT_MAX - 1.
  function automatic int unsigned div_cnt_width(input int unsigned div_base);
    return $clog2(div_base << SPEED_SHIFT_MAX);
  endfunction

  function automatic logic [31:0] div_terminal(input int unsigned div_base,
                                               input speed_t      speed);
    logic [1:0] shamt;
    shamt = 2'(SPEED_SHIFT_MAX) - speed;
    return (32'(div_base) << shamt) - 32'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchroniser, optional debounce filter, rising-edge detector.
// The filter is built only when BLINK_TICK_DEBOUNCE_EN is defined; otherwise the level is the synchroniser output.
module btn_debounce
  import blink_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic level_s;

  // Synchroniser next-state.
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef BLINK_TICK_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;

  // The level flips on the edge where the disagreement has lasted DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_cnt_d = {DB_W{1'b0}};
    level_d  = level_q;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d  = sync2_q;
        db_cnt_d = {DB_W{1'b0}};
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1'b1);
      end
    end else begin
      db_cnt_d = {DB_W{1'b0}};
    end
  end

  // Debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= {DB_W{1'b0}};
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  assign level_s = level_q;
`else
  assign level_s = sync2_q;
`endif

  // Edge detector next-state and press pulse.
  always_comb begin
    prev_d  = level_s;
    press_o = level_s & ~prev_q;
    level_o = level_s;
  end

  // Edge detector history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/blink_tick_gen.sv
// Programmable slow-clock generator: TICK pulse and SLOW_CLK square wave, four button-selected speeds.
// Build option: BLINK_TICK_DEBOUNCE_EN enables the button debounce filter.
module blink_tick_gen
  import blink_pkg::*;
#(
  parameter int unsigned DIV_BASE        = 1_500_000,
  parameter int unsigned DEBOUNCE_CYCLES = 120_000
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       BTN,
  output logic       TICK,
  output logic       SLOW_CLK,
  output logic [1:0] SPEED
);

  localparam int unsigned CNT_W = div_cnt_width(DIV_BASE);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] term_s;
  logic             tick_q, tick_d;
  logic             slow_q, slow_d;
  speed_t           speed_q, speed_d;
  logic             press_s;
  logic             level_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (CLK),
    .rst_n  (RSTN),
    .btn_i  (BTN),
    .level_o(level_s),
    .press_o(press_s)
  );

  // Divider, tick and speed next-state; a press outranks a coincident terminal count.
  always_comb begin
    term_s  = CNT_W'(div_terminal(DIV_BASE, speed_q));
    count_d = count_q;
    tick_d  = 1'b0;
    slow_d  = slow_q;
    speed_d = speed_q;
    if (press_s && level_s) begin
      count_d = {CNT_W{1'b0}};
      if (speed_q == SPEED_MAX) begin
        speed_d = 2'd0;
      end else begin
        speed_d = speed_q + 2'd1;
      end
    end else if (count_q == term_s) begin
      count_d = {CNT_W{1'b0}};
      tick_d  = 1'b1;
      slow_d  = ~slow_q;
    end else begin
      count_d = count_q + CNT_W'(1'b1);
    end
  end

  // Divider, output and speed registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_q <= {CNT_W{1'b0}};
      tick_q  <= 1'b0;
      slow_q  <= 1'b0;
      speed_q <= 2'd0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      slow_q  <= slow_d;
      speed_q <= speed_d;
    end
  end

  assign TICK     = tick_q;
  assign SLOW_CLK = slow_q;
  assign SPEED    = speed_q;

endmodule
